hsm_bus_master: RTL
===================

# hsm_bus_master

Initiator for the byte-wide chip-select GPIO bus to the HSM. It drives chip select, a strobe and the shared tristate data pins, and completes one write or read per request. It waits for a four-phase acknowledge from the target and reports the result on a response port. It sits between internal request logic and the GPIO pins, opposite the target-side transceiver. Bus convention: `chip_select` high means the initiator drives the pins and the target reads them; low means the target drives and the initiator reads.

## Interface
- `DATA_WIDTH`, 8: data bus width.
- `SETUP_CYCLES`, 2: cycles the pins and chip select are stable before the strobe rises; ≥1.
- `HOLD_CYCLES`, 2: cycles after the strobe falls before the pins are released; ≥1.
- `TIMEOUT`, 255: maximum cycles to wait for each acknowledge edge; ≥1, counter width `$clog2(TIMEOUT+1)`.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request (IDLE only).
- `req_write`  in  1  1 = write, 0 = read.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 on writes and timeouts.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: an acknowledge edge timed out.
- `chip_select`  out  1  bus direction / select.
- `strobe`  out  1  transfer strobe.
- `ack`  in  1  target acknowledge, asynchronous.
- `data_pins`  inout  DATA_WIDTH  shared bus; high-Z unless the initiator's drive enable is set.

## Operation
- `ack` passes through a 2-flop synchronizer to give `ack_s`. All decisions use `ack_s`.
- A request is accepted when `req_valid && req_ready` at a rising edge. `req_write` and `req_wdata` are latched at that edge.
- The drive enable is registered. The pins are driven only when the drive enable is 1, which implies `chip_select` is 1.
- States:
  - IDLE: `chip_select`=0, `strobe`=0, pins Z, `req_ready`=1. On accept, a write goes to TURN and a read goes to SETUP.
  - TURN (write only, 1 cycle): `chip_select`=1, pins still Z so the target can release them. Then go to SETUP.
  - SETUP (SETUP_CYCLES cycles): for a write, `chip_select`=1 and wdata driven. For a read, `chip_select`=0 and pins Z. Then go to STROBE.
  - STROBE: `strobe`=1. Leave on the first cycle with `ack_s`=1; for a read, capture `data_pins` into `rsp_rdata` at that edge. Alternatively leave after TIMEOUT cycles without `ack_s`, setting the timeout flag. Either way go to HOLD.
  - HOLD (HOLD_CYCLES cycles): `strobe`=0. Write data is still driven. Then go to ACKLOW.
  - ACKLOW: `strobe`=0, bus as in HOLD. Wait for `ack_s`=0, or TIMEOUT cycles, which sets the timeout flag. Then go to RELEASE.
  - RELEASE (1 cycle): pins Z. `chip_select` stays 1 for writes and 0 for reads. Then go to DONE.
  - DONE (1 cycle): `chip_select`=0, `rsp_valid`=1, `rsp_timeout`=flag, `rsp_rdata` valid. Then go to IDLE.
- The timeout counter clears on entry to STROBE and on entry to ACKLOW.
- On a timed-out read, `rsp_rdata`=0.
- The first timeout skips nothing: the full HOLD/ACKLOW/RELEASE sequence always runs, so the bus returns to a safe state.
- `req_valid` outside IDLE is ignored, and the request is not consumed.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_timeout`=0, `chip_select`=0, `strobe`=0, pins Z, synchronizer=0, state IDLE.
- Reset is asynchronous and takes effect immediately, including mid-transfer: the strobe drops and the pins release in the same instant.
- All outputs are registered and change only on `clk` rising edges.
- Write latency from the accept edge to `rsp_valid`: 1 (TURN) + SETUP_CYCLES + strobe-cycles + HOLD_CYCLES + acklow-cycles + 1 + 1.
  - strobe-cycles ≥ 1. If `ack` is already high at strobe entry, STROBE takes 1 cycle.
- Read latency is the same without TURN.
- Back-to-back: `req_ready` returns the cycle after DONE, so there is at most one transfer every (latency+1) cycles.
- The target must hold read data stable while `ack` is high.

## Test plan
- Write 0xA5, SETUP=2, HOLD=2, target raises `ack` 1 cycle after seeing `strobe`, drops it 1 cycle after `strobe` falls:
  - pins Z during TURN, 0xA5 from SETUP through HOLD/ACKLOW, Z in RELEASE;
  - one `rsp_valid` with `rsp_timeout`=0 and `rsp_rdata`=0.
- Read, target drives 0x3C while `chip_select`=0 and raises `ack` after the strobe:
  - initiator never drives the pins;
  - `rsp_rdata`=0x3C, `rsp_timeout`=0.
- Read, `ack` held 0, TIMEOUT=8:
  - `strobe` high exactly 8 cycles;
  - then HOLD, ACKLOW (immediate exit), RELEASE;
  - `rsp_valid` with `rsp_timeout`=1 and `rsp_rdata`=0.
- Target raises `ack` but never lowers it, TIMEOUT=8:
  - ACKLOW lasts 8 cycles;
  - `rsp_timeout`=1;
  - a following write still completes normally once `ack` is released.
- `req_valid` held high for two writes (0x11, 0x22):
  - two responses in order;
  - `req_ready` low from the first accept until after the first DONE;
  - no pin contention in between.
- `rst` asserted mid-STROBE of a write:
  - `strobe`=0, `chip_select`=0, pins Z asynchronously;
  - no `rsp_valid`;
  - `req_ready`=1 after release.

Source files
------------

// File: rtl/hsm_bus_if.sv
// HSM chip-select GPIO bus: request/response handshake and bus control.
// The shared data pins stay a plain inout on the master module.
interface hsm_bus_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_timeout;
  logic                  chip_select;
  logic                  strobe;
  logic                  ack;

  modport master (
    input  req_valid, req_write, req_wdata, ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output chip_select, strobe
  );

  modport slave (
    output req_valid, req_write, req_wdata, ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  chip_select, strobe
  );
endinterface

// File: rtl/hsm_bus_master.sv
// Initiator for the byte-wide chip-select GPIO bus to the HSM.
// One write or read per request, four-phase ack with per-edge timeout.
module hsm_bus_master #(
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  hsm_bus_if.master             bus,
  inout  wire  [DATA_WIDTH-1:0] data_pins
);

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int PMAX = (SETUP_CYCLES > HOLD_CYCLES) ?
                        SETUP_CYCLES : HOLD_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] S_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] H_LAST = PW'(HOLD_CYCLES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TURN    = 3'd1;
  localparam logic [2:0] SETUP   = 3'd2;
  localparam logic [2:0] STROBE  = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] ACKLOW  = 3'd5;
  localparam logic [2:0] RELEASE = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]            state;
  logic [2:0]            state_n;
  logic [PW-1:0]         pcnt;
  logic [TW-1:0]         tcnt;
  logic                  ack_m;
  logic                  ack_s;
  logic                  wr;
  logic                  wr_n;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  drive_en;
  logic                  cs;
  logic                  stb;
  logic                  ready;
  logic                  rsp_v;
  logic                  rsp_to;
  logic                  to_flag;

  logic accept;
  logic t_last;
  logic strobe_to;
  logic acklow_to;
  logic capture;

  assign accept    = ready && bus.req_valid;
  assign t_last    = (tcnt == T_LAST);
  assign strobe_to = (state == STROBE) && !ack_s && t_last;
  assign acklow_to = (state == ACKLOW) && ack_s && t_last;
  assign capture   = (state == STROBE) && ack_s && !wr;
  assign wr_n      = accept ? bus.req_write : wr;

  assign data_pins = drive_en ? wdata : {DATA_WIDTH{1'bz}};

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = rsp_v;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_timeout = rsp_to;
  assign bus.chip_select = cs;
  assign bus.strobe      = stb;

  // Two-flop synchronizer for the asynchronous target acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.ack;
      ack_s <= ack_m;
    end
  end

  // Next-state selection; a timeout never skips the return sequence.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = bus.req_write ? TURN : SETUP;
      TURN:    state_n = SETUP;
      SETUP:   if (pcnt == S_LAST) state_n = STROBE;
      STROBE:  if (ack_s || t_last) state_n = HOLD;
      HOLD:    if (pcnt == H_LAST) state_n = ACKLOW;
      ACKLOW:  if (!ack_s || t_last) state_n = RELEASE;
      RELEASE: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counters, latched request, and outputs decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      tcnt     <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
      rdata    <= '0;
      to_flag  <= 1'b0;
      drive_en <= 1'b0;
      cs       <= 1'b0;
      stb      <= 1'b0;
      ready    <= 1'b1;
      rsp_v    <= 1'b0;
      rsp_to   <= 1'b0;
    end else begin
      state <= state_n;
      wr    <= wr_n;

      if (state_n != state)
        pcnt <= '0;
      else if (state == SETUP || state == HOLD)
        pcnt <= pcnt + 1'b1;

      if (state_n != state)
        tcnt <= '0;
      else if (state == STROBE || state == ACKLOW)
        tcnt <= tcnt + 1'b1;

      if (accept)
        wdata <= bus.req_wdata;

      if (accept || acklow_to)
        rdata <= '0;
      else if (capture)
        rdata <= data_pins;

      if (accept)
        to_flag <= 1'b0;
      else if (strobe_to || acklow_to)
        to_flag <= 1'b1;

      cs       <= wr_n && (state_n != IDLE) && (state_n != DONE);
      drive_en <= wr_n && (state_n == SETUP || state_n == STROBE ||
                           state_n == HOLD  || state_n == ACKLOW);
      stb      <= (state_n == STROBE);
      ready    <= (state_n == IDLE);
      rsp_v    <= (state_n == DONE);
      rsp_to   <= (state_n == DONE) && to_flag;
    end
  end

endmodule
